acl_spi_master: RTL

SPI master for the ADXL362 accelerometer, clocked by the 4 MHz clock from the board clock divider. After power-up it puts the sensor into measurement mode, then periodically burst-reads the X/Y/Z data registers. It presents the latest sample as three 16-bit raw words with a one-cycle valid strobe to the shot-detection logic downstream. SCLK is generated internally at 1 MHz (clk_4MHz / 4), SPI mode 0, MSB first.

---
 rtl/acl_spi_master.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/acl_spi_master.sv
// acl_spi_master: ADXL362 SPI master; configures measurement mode, then periodically burst-reads X/Y/Z.
// Ports:
//    clk_4MHz    in   4 MHz system clock, SCLK is derived as clk_4MHz/4
//    CPU_RESETN  in   asynchronous active-low reset
//    ACL_MISO    in   sensor serial data out, sampled as SCLK rises
//    ACL_SCLK    out  SPI clock, mode 0, idles low
//    ACL_MOSI    out  sensor serial data in, MSB first
//    ACL_CSN     out  chip select, active low
//    acl_x/y/z   out  latest raw samples {DATA_H, DATA_L}
//    data_valid  out  one-cycle strobe when acl_x/y/z update
//    cfg_done    out  high once the POWER_CTL write has completed
module acl_spi_master #(
   parameter int STARTUP_WAIT = 20000,
   parameter int SAMPLE_DIV   = 40000,
   parameter int CS_GAP       = 4
) (
   input  logic        clk_4MHz,
   input  logic        CPU_RESETN,
   input  logic        ACL_MISO,
   output logic        ACL_SCLK,
   output logic        ACL_MOSI,
   output logic        ACL_CSN,
   output logic [15:0] acl_x,
   output logic [15:0] acl_y,
   output logic [15:0] acl_z,
   output logic        data_valid,
   output logic        cfg_done
);
   localparam int WW = $clog2(STARTUP_WAIT + 1);
   localparam int PW = $clog2(SAMPLE_DIV + 1);
   localparam int GW = $clog2(CS_GAP + 1);
   localparam logic [63:0] CFG_WORD = {24'h0A2D02, 40'h0};
   localparam logic [63:0] RD_WORD  = {16'h0B0E, 48'h0};

   typedef enum logic [2:0] {S_WAIT, S_CFG, S_IDLE, S_READ, S_LATCH, S_GAP} state_t;

   state_t        state_q;
   logic [WW-1:0] wt_q;
   logic [PW-1:0] per_q, per_d;
   logic [GW-1:0] gp_q;
   logic [8:0]    cyc_q, cyc_d, last_cyc;
   logic [63:0]   tx_q, load_word;
   logic [47:0]   rx_q, rx_d;
   logic          csn_q, sclk_q, mosi_q, dv_q, done_q;
   logic [15:0]   x_q, y_q, z_q;
   logic          per_wrap, start_d, frame_end;

   always_comb begin
      per_wrap  = per_q == PW'(SAMPLE_DIV - 1);
      per_d     = per_wrap ? '0 : per_q + 1'b1;
      cyc_d     = cyc_q + 9'd1;
      // a frame is 4N+1 cycles: N bit cells plus one CS hold cycle
      last_cyc  = (state_q == S_CFG) ? 9'd96 : 9'd256;
      frame_end = cyc_q == last_cyc;
      rx_d      = {rx_q[46:0], ACL_MISO};
      start_d   = (state_q == S_WAIT && wt_q == WW'(STARTUP_WAIT - 1)) || (state_q == S_IDLE && per_wrap);
      load_word = (state_q == S_WAIT) ? CFG_WORD : RD_WORD;
   end

   always_ff @(posedge clk_4MHz or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state_q <= S_WAIT;
         wt_q    <= '0;
         per_q   <= '0;
         gp_q    <= '0;
         cyc_q   <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         csn_q   <= 1'b1;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         dv_q    <= 1'b0;
         done_q  <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
      end else begin
         // period counter free-runs once configured so read starts stay exactly SAMPLE_DIV apart
         if (done_q) per_q <= per_d;
         if (start_d) begin
            state_q <= (state_q == S_WAIT) ? S_CFG : S_READ;
            csn_q   <= 1'b0;
            mosi_q  <= load_word[63];
            tx_q    <= {load_word[62:0], 1'b0};
            cyc_q   <= '0;
         end else begin
            case (state_q)
               S_WAIT: wt_q <= wt_q + 1'b1;
               S_CFG, S_READ: begin
                  if (frame_end) begin
                     csn_q  <= 1'b1;
                     sclk_q <= 1'b0;
                     mosi_q <= 1'b0;
                     gp_q   <= '0;
                     if (state_q == S_CFG) begin
                        done_q  <= 1'b1;
                        state_q <= S_GAP;
                     end else begin
                        // rx holds XL,XH,YL,YH,ZL,ZH from MSB down; command-phase bits have shifted out
                        x_q     <= {rx_q[39:32], rx_q[47:40]};
                        y_q     <= {rx_q[23:16], rx_q[31:24]};
                        z_q     <= {rx_q[7:0], rx_q[15:8]};
                        dv_q    <= 1'b1;
                        state_q <= S_LATCH;
                     end
                  end else begin
                     cyc_q <= cyc_d;
                     if (cyc_d[1:0] == 2'd2) begin
                        sclk_q <= 1'b1;
                        rx_q   <= rx_d;
                     end
                     if (cyc_d[1:0] == 2'd0) begin
                        sclk_q <= 1'b0;
                        mosi_q <= (cyc_d == last_cyc) ? 1'b0 : tx_q[63];
                        tx_q   <= {tx_q[62:0], 1'b0};
                     end
                  end
               end
               S_LATCH: begin
                  dv_q    <= 1'b0;
                  gp_q    <= gp_q + 1'b1;
                  state_q <= S_GAP;
               end
               S_GAP: begin
                  if (gp_q >= GW'(CS_GAP - 1)) state_q <= S_IDLE;
                  else gp_q <= gp_q + 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign ACL_CSN    = csn_q;
   assign ACL_SCLK   = sclk_q;
   assign ACL_MOSI   = mosi_q;
   assign acl_x      = x_q;
   assign acl_y      = y_q;
   assign acl_z      = z_q;
   assign data_valid = dv_q;
   assign cfg_done   = done_q;
endmodule
